imm_target_pipe: RTL and testbench

- Parametrised successor of the RV32I immediate generator.
- Decodes the instruction format from the opcode and produces one sign-extended (or legacy zero-extended) immediate, plus the PC-relative target for B, J and AUIPC.
- Flags misaligned targets and illegal opcodes.
- Sits between fetch/decode and execute as a 1- or 2-stage valid/ready pipeline, so the target adder leaves the single-cycle critical path.

---
 rtl/imm_target_pipe.sv | 212 +++++++++++++++++++++
 tb/tb_imm_target_pipe.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imm_target_pipe.sv
// RV32I immediate decode with PC-relative target, wrapped in a 1- or 2-stage
// valid/ready pipeline. The second stage exists only to take the target adder
// off the decode cycle.
module imm_target_pipe #(
   parameter int XLEN     = 32,
   parameter int SIGN_EXT = 1,
   parameter int STAGES   = 2,
   parameter int IALIGN   = 4
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [31:0]     in_instr,
   input  logic [XLEN-1:0] in_pc,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] out_imm,
   output logic [2:0]      out_fmt,
   output logic [XLEN-1:0] out_target,
   output logic            out_misalign,
   output logic            out_illegal
);

   localparam logic [2:0] FMT_R   = 3'd0;
   localparam logic [2:0] FMT_I   = 3'd1;
   localparam logic [2:0] FMT_S   = 3'd2;
   localparam logic [2:0] FMT_B   = 3'd3;
   localparam logic [2:0] FMT_U   = 3'd4;
   localparam logic [2:0] FMT_J   = 3'd5;
   localparam logic [2:0] FMT_ILL = 3'd7;

   logic [2:0]      dec_fmt;
   logic            dec_tgt_en;
   logic            dec_bj;
   logic            dec_ill;
   logic            ext_bit;
   logic [XLEN-1:0] dec_imm;

   always_comb begin
      dec_fmt    = FMT_ILL;
      dec_tgt_en = 1'b0;
      dec_bj     = 1'b0;
      case (in_instr[6:0])
         7'b0010011, 7'b0000011, 7'b1100111, 7'b1110011, 7'b0001111: dec_fmt = FMT_I;
         7'b0100011: dec_fmt = FMT_S;
         7'b1100011: begin
            dec_fmt    = FMT_B;
            dec_tgt_en = 1'b1;
            dec_bj     = 1'b1;
         end
         7'b0110111: dec_fmt = FMT_U;
         7'b0010111: begin
            dec_fmt    = FMT_U;
            dec_tgt_en = 1'b1;
         end
         7'b1101111: begin
            dec_fmt    = FMT_J;
            dec_tgt_en = 1'b1;
            dec_bj     = 1'b1;
         end
         7'b0110011: dec_fmt = FMT_R;
         default:    dec_fmt = FMT_ILL;
      endcase
   end

   assign dec_ill = (dec_fmt == FMT_ILL);

   // Every RISC-V immediate has its sign in instr[31], so one extension bit
   // serves all formats (including U extending from bit 31 on RV64).
   assign ext_bit = (SIGN_EXT != 0) && in_instr[31];

   always_comb begin
      dec_imm = {XLEN{ext_bit}};
      case (dec_fmt)
         FMT_I:   dec_imm[11:0] = in_instr[31:20];
         FMT_S:   dec_imm[11:0] = {in_instr[31:25], in_instr[11:7]};
         FMT_B:   dec_imm[12:0] = {in_instr[31], in_instr[7], in_instr[30:25],
                                   in_instr[11:8], 1'b0};
         FMT_U:   dec_imm[31:0] = {in_instr[31:12], 12'b0};
         FMT_J:   dec_imm[20:0] = {in_instr[31], in_instr[19:12], in_instr[20],
                                   in_instr[30:21], 1'b0};
         default: dec_imm = '0;
      endcase
   end

   function automatic logic mis_of(input logic [XLEN-1:0] t);
      if (IALIGN == 2) return t[0];
      else             return |t[1:0];
   endfunction

   if (STAGES == 1) begin : g_one
      logic            valid_q;
      logic [XLEN-1:0] imm_q;
      logic [XLEN-1:0] tgt_q;
      logic [XLEN-1:0] tgt_d;
      logic [2:0]      fmt_q;
      logic            mis_q;
      logic            mis_d;
      logic            ill_q;
      logic            load;

      assign load     = !valid_q || out_ready;
      assign in_ready = load;
      assign tgt_d    = dec_tgt_en ? (in_pc + dec_imm) : '0;
      assign mis_d    = dec_bj && mis_of(tgt_d);

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            valid_q <= 1'b0;
            imm_q   <= '0;
            tgt_q   <= '0;
            fmt_q   <= '0;
            mis_q   <= 1'b0;
            ill_q   <= 1'b0;
         end else if (load) begin
            valid_q <= in_valid;
            if (in_valid) begin
               imm_q <= dec_imm;
               tgt_q <= tgt_d;
               fmt_q <= dec_fmt;
               mis_q <= mis_d;
               ill_q <= dec_ill;
            end
         end
      end

      assign out_valid    = valid_q;
      assign out_imm      = imm_q;
      assign out_fmt      = fmt_q;
      assign out_target   = tgt_q;
      assign out_misalign = mis_q;
      assign out_illegal  = ill_q;
   end else begin : g_two
      logic            s1_valid_q;
      logic [2:0]      s1_fmt_q;
      logic [XLEN-1:0] s1_imm_q;
      logic [XLEN-1:0] s1_pc_q;
      logic            s1_ill_q;
      logic            s1_tgt_en_q;
      logic            s1_bj_q;
      logic            s2_valid_q;
      logic [2:0]      s2_fmt_q;
      logic [XLEN-1:0] s2_imm_q;
      logic            s2_ill_q;
      logic [XLEN-1:0] s2_tgt_q;
      logic [XLEN-1:0] s2_tgt_d;
      logic            s2_mis_q;
      logic            s2_mis_d;
      logic            s2_load;
      logic            s1_advance;
      logic            s1_load;

      assign s2_load    = !s2_valid_q || out_ready;
      assign s1_advance = s1_valid_q && s2_load;
      assign s1_load    = !s1_valid_q || s1_advance;
      assign in_ready   = s1_load;

      assign s2_tgt_d = s1_tgt_en_q ? (s1_pc_q + s1_imm_q) : '0;
      assign s2_mis_d = s1_bj_q && mis_of(s2_tgt_d);

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            s1_fmt_q    <= '0;
            s1_imm_q    <= '0;
            s1_pc_q     <= '0;
            s1_ill_q    <= 1'b0;
            s1_tgt_en_q <= 1'b0;
            s1_bj_q     <= 1'b0;
         end else if (s1_load) begin
            s1_valid_q <= in_valid;
            if (in_valid) begin
               s1_fmt_q    <= dec_fmt;
               s1_imm_q    <= dec_imm;
               s1_pc_q     <= in_pc;
               s1_ill_q    <= dec_ill;
               s1_tgt_en_q <= dec_tgt_en;
               s1_bj_q     <= dec_bj;
            end
         end
      end

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            s2_valid_q <= 1'b0;
            s2_fmt_q   <= '0;
            s2_imm_q   <= '0;
            s2_ill_q   <= 1'b0;
            s2_tgt_q   <= '0;
            s2_mis_q   <= 1'b0;
         end else if (s2_load) begin
            s2_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
               s2_fmt_q <= s1_fmt_q;
               s2_imm_q <= s1_imm_q;
               s2_ill_q <= s1_ill_q;
               s2_tgt_q <= s2_tgt_d;
               s2_mis_q <= s2_mis_d;
            end
         end
      end

      assign out_valid    = s2_valid_q;
      assign out_imm      = s2_imm_q;
      assign out_fmt      = s2_fmt_q;
      assign out_target   = s2_tgt_q;
      assign out_misalign = s2_mis_q;
      assign out_illegal  = s2_ill_q;
   end

endmodule

// File: tb/tb_imm_target_pipe.sv
// Bench for imm_target_pipe: three parameter variants share one input stream,
// each with its own scoreboard fed by an arithmetic reference model.
module tb_imm_target_pipe;

   typedef struct packed {
      logic [63:0] imm;
      logic [2:0]  fmt;
      logic [63:0] tgt;
      logic        mis;
      logic        ill;
   } res_t;

   logic        clk       = 1'b0;
   logic        rst_n     = 1'b1;
   logic        in_valid  = 1'b0;
   logic        out_ready = 1'b0;
   logic [31:0] in_instr  = '0;
   logic [63:0] pc        = '0;

   logic [2:0]        rdy, ov, mis, ill;
   logic [2:0][2:0]   fmt;
   logic [2:0][63:0]  imm, tgt;

   int   checks = 0;
   int   errors = 0;
   res_t sb [3][$];
   res_t held [3];
   logic [2:0] hold = '0;

   always #5 clk = ~clk;

   // u0: default build; u1: zero-extend, single stage, 2-byte alignment; u2: RV64
   imm_target_pipe #(.XLEN(32), .SIGN_EXT(1), .STAGES(2), .IALIGN(4)) u0 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy[0]),
      .in_instr(in_instr), .in_pc(pc[31:0]), .out_valid(ov[0]), .out_ready(out_ready),
      .out_imm(imm[0][31:0]), .out_fmt(fmt[0]), .out_target(tgt[0][31:0]),
      .out_misalign(mis[0]), .out_illegal(ill[0]));
   assign imm[0][63:32] = '0;
   assign tgt[0][63:32] = '0;

   imm_target_pipe #(.XLEN(32), .SIGN_EXT(0), .STAGES(1), .IALIGN(2)) u1 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy[1]),
      .in_instr(in_instr), .in_pc(pc[31:0]), .out_valid(ov[1]), .out_ready(out_ready),
      .out_imm(imm[1][31:0]), .out_fmt(fmt[1]), .out_target(tgt[1][31:0]),
      .out_misalign(mis[1]), .out_illegal(ill[1]));
   assign imm[1][63:32] = '0;
   assign tgt[1][63:32] = '0;

   imm_target_pipe #(.XLEN(64), .SIGN_EXT(1), .STAGES(2), .IALIGN(4)) u2 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy[2]),
      .in_instr(in_instr), .in_pc(pc), .out_valid(ov[2]), .out_ready(out_ready),
      .out_imm(imm[2]), .out_fmt(fmt[2]), .out_target(tgt[2]),
      .out_misalign(mis[2]), .out_illegal(ill[2]));

   function automatic int xl(input int k); return (k == 2) ? 64 : 32; endfunction
   function automatic int sx(input int k); return (k == 1) ? 0 : 1;   endfunction
   function automatic int st(input int k); return (k == 1) ? 1 : 2;   endfunction
   function automatic int ia(input int k); return (k == 1) ? 2 : 4;   endfunction

   function automatic res_t model(input logic [31:0] ins, input logic [63:0] pcv, input int k);
      res_t        r;
      logic [63:0] val;
      logic [63:0] mask;
      int          w;
      r    = '0;
      val  = '0;
      w    = 0;
      mask = (xl(k) == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
      case (ins[6:0])
         7'h13, 7'h03, 7'h67, 7'h73, 7'h0F: begin
            r.fmt = 3'd1; val = 64'(ins[31:20]); w = 12;
         end
         7'h23: begin r.fmt = 3'd2; val = 64'({ins[31:25], ins[11:7]}); w = 12; end
         7'h63: begin
            r.fmt = 3'd3; w = 13;
            val = 64'({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0});
         end
         7'h37, 7'h17: begin r.fmt = 3'd4; val = 64'({ins[31:12], 12'h000}); w = 32; end
         7'h6F: begin
            r.fmt = 3'd5; w = 21;
            val = 64'({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0});
         end
         7'h33: r.fmt = 3'd0;
         default: begin r.fmt = 3'd7; r.ill = 1'b1; end
      endcase
      // Two's complement: a negative field of width w equals val - 2^w
      if (sx(k) == 1 && w > 0 && val[w-1]) val = val - (64'd1 << w);
      r.imm = val & mask;
      if (r.fmt == 3'd3 || r.fmt == 3'd5 || ins[6:0] == 7'h17)
         r.tgt = (pcv + r.imm) & mask;
      if (r.fmt == 3'd3 || r.fmt == 3'd5)
         r.mis = (r.tgt % 64'(ia(k))) != 64'd0;
      return r;
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic monitor();
      if (!rst_n) return;
      for (int k = 0; k < 3; k++) begin
         res_t o;
         res_t e;
         o.imm = imm[k]; o.fmt = fmt[k]; o.tgt = tgt[k]; o.mis = mis[k]; o.ill = ill[k];
         if (hold[k]) begin
            chk($sformatf("dut%0d_hold_valid", k), 64'(ov[k]), 64'd1);
            chk($sformatf("dut%0d_hold_imm", k), o.imm, held[k].imm);
            chk($sformatf("dut%0d_hold_tgt", k), o.tgt, held[k].tgt);
            chk($sformatf("dut%0d_hold_flags", k), 64'({o.fmt, o.mis, o.ill}),
                64'({held[k].fmt, held[k].mis, held[k].ill}));
         end
         if (ov[k] && out_ready) begin
            hold[k] = 1'b0;
            if (sb[k].size() == 0) begin
               checks++;
               errors++;
               $error("FAIL dut%0d_spurious observed=valid expected=no_pending_result", k);
            end else begin
               e = sb[k].pop_front();
               chk($sformatf("dut%0d_imm", k), o.imm, e.imm);
               chk($sformatf("dut%0d_fmt", k), 64'(o.fmt), 64'(e.fmt));
               chk($sformatf("dut%0d_target", k), o.tgt, e.tgt);
               chk($sformatf("dut%0d_misalign", k), 64'(o.mis), 64'(e.mis));
               chk($sformatf("dut%0d_illegal", k), 64'(o.ill), 64'(e.ill));
               $display("txn dut%0d fmt=%0d imm=%h target=%h misalign=%0b illegal=%0b",
                        k, o.fmt, o.imm, o.tgt, o.mis, o.ill);
            end
         end else begin
            hold[k] = ov[k];
            held[k] = o;
         end
         if (in_valid && rdy[k]) sb[k].push_back(model(in_instr, pc, k));
      end
   endtask

   task automatic cycle();
      @(negedge clk);
      monitor();
      @(posedge clk);
      #1;
   endtask

   task automatic single(input logic [31:0] ins, input logic [63:0] p,
                         input logic [63:0] e_imm, input logic [2:0] e_fmt,
                         input logic [63:0] e_tgt, input logic e_mis, input logic e_ill,
                         input logic [63:0] e1_imm, input logic [63:0] e1_tgt,
                         input logic e1_mis);
      in_instr  = ins;
      pc        = p;
      in_valid  = 1'b1;
      out_ready = 1'b1;
      chk("accept_ready", 64'(rdy[0]), 64'd1);
      cycle();
      in_valid = 1'b0;
      for (int k = 0; k < 3; k++)
         chk($sformatf("dut%0d_latency_first", k), 64'(ov[k]), 64'(st(k) == 1));
      chk("u1_imm", imm[1], e1_imm);
      chk("u1_target", tgt[1], e1_tgt);
      chk("u1_misalign", 64'(mis[1]), 64'(e1_mis));
      cycle();
      chk("dut0_latency_second", 64'(ov[0]), 64'd1);
      chk("dut2_latency_second", 64'(ov[2]), 64'd1);
      chk("u0_imm", imm[0], e_imm);
      chk("u0_fmt", 64'(fmt[0]), 64'(e_fmt));
      chk("u0_target", tgt[0], e_tgt);
      chk("u0_misalign", 64'(mis[0]), 64'(e_mis));
      chk("u0_illegal", 64'(ill[0]), 64'(e_ill));
      cycle();
   endtask

   task automatic drain();
      in_valid  = 1'b0;
      out_ready = 1'b1;
      for (int n = 0; n < 12; n++) begin
         if (sb[0].size() + sb[1].size() + sb[2].size() == 0) break;
         cycle();
      end
      for (int k = 0; k < 3; k++)
         chk($sformatf("dut%0d_drained", k), 64'(sb[k].size()), 64'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] bp_ins [4];
      int          idx;
      logic        acc;

      // Asynchronous reset with no clock edge in between
      #1 rst_n = 1'b0;
      #1;
      for (int k = 0; k < 3; k++) begin
         chk($sformatf("dut%0d_reset_valid", k), 64'(ov[k]), 64'd0);
         chk($sformatf("dut%0d_reset_imm", k), imm[k], 64'd0);
         chk($sformatf("dut%0d_reset_target", k), tgt[k], 64'd0);
         chk($sformatf("dut%0d_reset_flags", k), 64'({fmt[k], mis[k], ill[k]}), 64'd0);
      end
      chk("reset_in_ready", 64'(rdy[0]), 64'd1);
      #10 rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Directed: BEQ -4, JAL wrap, BEQ +6, LUI, illegal
      single(32'hFE000EE3, 64'h100, 64'hFFFF_FFFC, 3'd3, 64'h0000_00FC, 1'b0, 1'b0,
             64'h0000_1FFC, 64'h0000_20FC, 1'b0);
      single(32'h0080006F, 64'hFFFF_FFFC, 64'h8, 3'd5, 64'h4, 1'b0, 1'b0,
             64'h8, 64'h4, 1'b0);
      single(32'h00000363, 64'h100, 64'h6, 3'd3, 64'h106, 1'b1, 1'b0,
             64'h6, 64'h106, 1'b0);
      single(32'h123452B7, 64'h100, 64'h1234_5000, 3'd4, 64'h0, 1'b0, 1'b0,
             64'h1234_5000, 64'h0, 1'b0);
      single(32'h0000007F, 64'h100, 64'h0, 3'd7, 64'h0, 1'b0, 1'b1,
             64'h0, 64'h0, 1'b0);

      // Backpressure: four back-to-back instructions, consumer stalled 3 cycles
      bp_ins[0] = 32'h00100093;
      bp_ins[1] = 32'h00200113;
      bp_ins[2] = 32'h0080006F;
      bp_ins[3] = 32'hFE000EE3;
      idx       = 0;
      out_ready = 1'b0;
      repeat (3) begin
         in_valid = 1'b1;
         in_instr = bp_ins[idx];
         pc       = 64'h200 + 64'(4 * idx);
         acc      = rdy[0];
         cycle();
         if (acc) idx++;
      end
      chk("bp_in_ready_low", 64'(rdy[0]), 64'd0);
      chk("bp_accepted_two", 64'(idx), 64'd2);
      chk("bp_single_stage_ready_low", 64'(rdy[1]), 64'd0);
      out_ready = 1'b1;
      for (int c = 0; c < 4; c++) begin
         chk($sformatf("bp_no_gap_%0d", c), 64'(ov[0]), 64'd1);
         if (idx < 4) begin
            in_valid = 1'b1;
            in_instr = bp_ins[idx];
            pc       = 64'h200 + 64'(4 * idx);
         end else begin
            in_valid = 1'b0;
         end
         acc = in_valid && rdy[0];
         cycle();
         if (acc) idx++;
      end
      chk("bp_all_accepted", 64'(idx), 64'd4);
      drain();

      // Reset mid-stream while results are held
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_instr  = 32'h00500093;
      pc        = 64'h300;
      repeat (3) cycle();
      chk("rst_pre_valid", 64'(ov[0]), 64'd1);
      in_valid = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      for (int k = 0; k < 3; k++) begin
         chk($sformatf("dut%0d_midrst_valid", k), 64'(ov[k]), 64'd0);
         chk($sformatf("dut%0d_midrst_imm", k), imm[k], 64'd0);
         chk($sformatf("dut%0d_midrst_target", k), tgt[k], 64'd0);
         chk($sformatf("dut%0d_midrst_flags", k), 64'({fmt[k], mis[k], ill[k]}), 64'd0);
         sb[k].delete();
      end
      hold = '0;
      @(negedge clk);
      #2 rst_n = 1'b1;
      @(posedge clk);
      #1;
      single(32'h00000363, 64'h100, 64'h6, 3'd3, 64'h106, 1'b1, 1'b0,
             64'h6, 64'h106, 1'b0);

      // Randomised traffic with random valid/ready patterns
      for (int n = 0; n < 600; n++) begin
         logic [31:0] r;
         logic [6:0]  op;
         logic [63:0] pr;
         r = $urandom();
         case ($urandom_range(0, 11))
            0:  op = 7'h13;
            1:  op = 7'h03;
            2:  op = 7'h67;
            3:  op = 7'h73;
            4:  op = 7'h0F;
            5:  op = 7'h23;
            6:  op = 7'h63;
            7:  op = 7'h37;
            8:  op = 7'h17;
            9:  op = 7'h6F;
            10: op = 7'h33;
            default: op = r[6:0];
         endcase
         r        = $urandom();
         in_instr = {r[31:7], op};
         pr       = {32'($urandom()), 32'($urandom())};
         if ($urandom_range(0, 3) != 0) pr[1:0] = 2'b00;
         pc        = pr;
         in_valid  = ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 3) != 0);
         cycle();
      end
      drain();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
